// File: rtl/log2_frac.sv
// Sequential fixed-point log2: integer part from the leading one,
// fraction bits by iterative square-and-compare, one bit per clock.
module log2_frac #(
   parameter  int IN_WIDTH   = 16,
   parameter  int FRAC_WIDTH = 8,
   localparam int INT_WIDTH  = $clog2(IN_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [IN_WIDTH-1:0]           num,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INT_WIDTH+FRAC_WIDTH-1:0] log,
   output logic                          zero_err
);

   localparam int CNT_W = $clog2(FRAC_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

   state_t                          state;
   logic [IN_WIDTH-1:0]             num_reg;
   logic [IN_WIDTH-1:0]             m;
   logic [INT_WIDTH-1:0]            int_reg;
   logic [FRAC_WIDTH-1:0]           frac_reg;
   logic [CNT_W-1:0]                cnt;
   logic [INT_WIDTH+FRAC_WIDTH-1:0] log_reg;
   logic                            zero_err_reg;

   logic [INT_WIDTH-1:0]            msb;
   logic [IN_WIDTH-1:0]             m_norm;
   logic [2*IN_WIDTH-1:0]           p;
   logic                            fbit;
   logic [IN_WIDTH-1:0]             m_next;
   logic [FRAC_WIDTH-1:0]           frac_next;

   always_comb begin
      msb = '0;
      for (int i = 0; i < IN_WIDTH; i++)
         if (num_reg[i]) msb = INT_WIDTH'(i);
   end

   // Normalise to 1.(W-1) so the leading one sits at the MSB.
   assign m_norm = num_reg << (INT_WIDTH'(IN_WIDTH - 1) - msb);

   // Squaring doubles the log; an overflow past 2.0 yields a 1 bit.
   assign p         = {{IN_WIDTH{1'b0}}, m} * {{IN_WIDTH{1'b0}}, m};
   assign fbit      = p[2*IN_WIDTH-1];
   assign m_next    = fbit ? p[2*IN_WIDTH-1:IN_WIDTH]
                           : p[2*IN_WIDTH-2:IN_WIDTH-1];
   assign frac_next = FRAC_WIDTH'({frac_reg, fbit});

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign log       = log_reg;
   assign zero_err  = zero_err_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         num_reg      <= '0;
         m            <= '0;
         int_reg      <= '0;
         frac_reg     <= '0;
         cnt          <= '0;
         log_reg      <= '0;
         zero_err_reg <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  num_reg <= num;
                  state   <= NORM;
               end
            end
            NORM: begin
               int_reg <= msb;
               m       <= m_norm;
               if (num_reg == '0) begin
                  zero_err_reg <= 1'b1;
                  log_reg      <= '0;
                  state        <= DONE;
               end else begin
                  zero_err_reg <= 1'b0;
                  cnt          <= '0;
                  frac_reg     <= '0;
                  state        <= ITER;
               end
            end
            ITER: begin
               m        <= m_next;
               frac_reg <= frac_next;
               cnt      <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(FRAC_WIDTH - 1)) begin
                  log_reg <= {int_reg, frac_next};
                  state   <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/log2_frac.md
# log2_frac

Sequential fixed-point base-2 logarithm unit.
- Accepts an unsigned IN_WIDTH-bit integer over a valid/ready handshake.
- Result: integer part = index of the most significant set bit; FRAC_WIDTH fraction bits computed by iterative square-and-compare, one bit per clock.
- Successor to the combinational integer log2 encoder; used wherever a finer log estimate is needed (gain/level computation) and a multi-cycle latency is acceptable.

## Interface
- IN_WIDTH, 16, input operand width; must be >= 2
- FRAC_WIDTH, 8, number of fractional result bits; must be >= 1
- INT_WIDTH, $clog2(IN_WIDTH), integer-part width (derived, not to be overridden)
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand present on num
- in_ready  output  1  block can accept an operand
- num  input  IN_WIDTH  unsigned operand; sampled on the accept edge
- out_valid  output  1  result present on log / zero_err
- out_ready  input  1  consumer takes the result
- log  output  INT_WIDTH+FRAC_WIDTH  result, unsigned fixed point, format {int, frac}
- zero_err  output  1  operand was 0; log is 0 in this case

## Operation
- FSM states: IDLE, NORM, ITER, DONE. Reset state: IDLE.
- in_ready = (state == IDLE). This is combinational from state, so in_ready is 1 during and after reset.
- Accept: in_valid && in_ready && !rst on a rising edge. num is registered and the FSM moves to NORM. In-flight input changes are ignored.
- NORM (1 cycle):
  - int = index of the highest set bit of the registered operand.
  - Mantissa m (IN_WIDTH bits, format 1.(IN_WIDTH-1)) = operand << (IN_WIDTH-1-int).
  - If the operand is 0: zero_err_reg = 1, log_reg = 0, next state DONE.
  - Otherwise: zero_err_reg = 0, frac counter = 0, next state ITER.
- ITER (exactly FRAC_WIDTH cycles), each cycle:
  - p = m*m, 2*IN_WIDTH bits, format 2.(2*IN_WIDTH-2).
  - If p[2W-1] = 1: fraction bit = 1, m = p[2W-1:W].
  - Else: fraction bit = 0, m = p[2W-2:W-1].
  - W = IN_WIDTH. Truncation only; no rounding.
  - Fraction bits are shifted in MSB first.
  - After bit FRAC_WIDTH-1: log_reg = {int, frac}, next state DONE.
- DONE:
  - out_valid = 1. log and zero_err are held stable until out_valid && out_ready.
  - Then next state IDLE.
- out_valid = (state == DONE). log and zero_err are registered and change only in NORM/ITER/DONE transitions.
- out_ready outside DONE is ignored. in_valid outside IDLE is ignored; the producer must hold it.
- Exact powers of two: m = 1.0 throughout, so all fraction bits are 0.
- Reset values: state IDLE, log 0, zero_err 0, out_valid 0, in_ready 1, internal registers 0.
- rst asserted mid-operation (any state): immediate return to the reset values; the operation in progress is discarded and no result is produced.

## Timing
- Accept edge = cycle 0. NORM is cycle 1, and ITER spans cycles 2 .. FRAC_WIDTH+1.
- Nonzero operand: out_valid is first high in cycle FRAC_WIDTH+2 (cycle 10 at defaults).
- Zero operand: out_valid is first high in cycle 2.
- out_ready high on the first DONE cycle: IDLE (in_ready = 1) in the next cycle.
- No overlap between operations. Maximum throughput is one result per FRAC_WIDTH+3 cycles; the zero-operand case takes 3 cycles.
- Backpressure: out_valid stays high indefinitely while out_ready = 0; the result does not change.
- Critical path: one IN_WIDTH x IN_WIDTH multiply per cycle in ITER.

## Test plan
- Reset, then num=1: log = 0x000, zero_err = 0, out_valid in cycle 10.
- num = 2^k for k = 0..15 (defaults): log = {k, 8'h00}; num=16'h8000 -> log = 0xF00.
- num=3 -> log = 0x195 (1 + 149/256). num=16'hFFFF -> int 0xF with frac = floor of exact fraction (log2(65535) = 15.99998 -> 0xFFF). Compare all outputs against a bit-exact model of the square-and-compare algorithm for 1000 random nonzero operands.
- num=0: out_valid in cycle 2, zero_err = 1, log = 0. The next operation (num=5 -> log = 0x252) must have zero_err = 0.
- Backpressure:
  - Hold out_ready = 0 for 20 cycles after out_valid: log stays stable and in_ready stays 0 with in_valid high.
  - Release out_ready: one handshake, then in_ready = 1 next cycle.
- Pulse rst during ITER (cycle 5): all outputs return to reset values asynchronously. No out_valid follows. A fresh num=3 afterwards still yields 0x195.
